// File: rtl/cache_pkg.sv
// Shared types and helpers for the write-back data cache.
// Holds the miss/flush state encoding, address-split constants and byte-merge logic.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        FLUSH_SCAN,
        FLUSH_WB
    } cache_state_t;

    localparam int OFFSET_W = 2;

    // Tag is whatever sits above the word offset and the line index.
    function automatic logic [63:0] tag_of(input logic [63:0] addr, input int index_w);
        return addr >> (OFFSET_W + index_w);
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/data/valid/dirty storage for a direct-mapped cache of one-word lines.
// Combinational read port, one byte-enable write port and a per-line dirty clear.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int TAG_W = 26
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [$clog2(LINES)-1:0] rd_idx_i,
    output logic [TAG_W-1:0]         rd_tag_o,
    output logic [31:0]              rd_data_o,
    output logic                     rd_valid_o,
    output logic                     rd_dirty_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(LINES)-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic [31:0]              wr_data_i,
    input  logic [3:0]               wr_be_i,
    input  logic                     wr_dirty_i,
    input  logic                     clr_en_i,
    input  logic [$clog2(LINES)-1:0] clr_idx_i
);

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [31:0]      merged_d;

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];

    assign merged_d = be_merge(data_q[wr_idx_i], wr_data_i, wr_be_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (clr_en_i) dirty_q[clr_idx_i] <= 1'b0;
            if (wr_en_i) begin
                valid_q[wr_idx_i] <= 1'b1;
                dirty_q[wr_idx_i] <= wr_dirty_i;
            end
        end
    end

    // Tag and data are never reset; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= merged_d;
        end
    end

endmodule

// File: rtl/wb_cache.sv
// Write-back, write-allocate, direct-mapped data cache with a blocking miss FSM,
// byte-enable stores, a dirty-line flush walk and saturating hit/miss counters.
module wb_cache
    import cache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [3:0]        core_be,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(LINES - 1);

    cache_state_t       state_q, state_d;
    logic [INDEX_W-1:0] idx_q, idx_d, scan_q, scan_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               refill_pend_q, refill_pend_d;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;
    logic               hit_inc, miss_inc;

    logic [INDEX_W-1:0] core_idx, rd_idx, wr_idx;
    logic [63:0]        core_tag_full;
    logic [TAG_W-1:0]   core_tag, rd_tag, wr_tag;
    logic [31:0]        rd_data, wr_data;
    logic [3:0]         wr_be;
    logic               rd_valid, rd_dirty, wr_en, wr_dirty, clr_en, hit;
    logic               unused_bits;

    assign core_idx      = core_addr[OFFSET_W +: INDEX_W];
    assign core_tag_full = tag_of(64'(core_addr), INDEX_W);
    assign core_tag      = core_tag_full[TAG_W-1:0];
    assign unused_bits   = ^{core_addr[OFFSET_W-1:0], core_tag_full[63:TAG_W]};
    assign hit           = rd_valid && (rd_tag == core_tag);

    assign core_rdata = rd_data;
    assign mem_wdata  = rd_data;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

    always_comb begin
        case (state_q)
            IDLE:                 rd_idx = core_idx;
            FLUSH_SCAN, FLUSH_WB: rd_idx = scan_q;
            default:              rd_idx = idx_q;
        endcase
    end

    cache_line_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk_i      (clk),
        .rst_i      (rst_b),
        .rd_idx_i   (rd_idx),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_tag_i   (wr_tag),
        .wr_data_i  (wr_data),
        .wr_be_i    (wr_be),
        .wr_dirty_i (wr_dirty),
        .clr_en_i   (clr_en),
        .clr_idx_i  (scan_q)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tag_d         = tag_q;
        scan_d        = scan_q;
        refill_pend_d = refill_pend_q;
        core_ready    = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = {tag_q, idx_q, {OFFSET_W{1'b0}}};
        flush_done    = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = core_idx;
        wr_tag        = core_tag;
        wr_data       = core_wdata;
        wr_be         = core_be;
        wr_dirty      = 1'b1;
        clr_en        = 1'b0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH_SCAN;
                    scan_d  = '0;
                end else if (core_req) begin
                    if (hit) begin
                        core_ready = 1'b1;
                        wr_en      = core_we;
                        // The completion right after a refill is the tail of a miss.
                        if (refill_pend_q) refill_pend_d = 1'b0;
                        else               hit_inc       = 1'b1;
                    end else begin
                        miss_inc = 1'b1;
                        idx_d    = core_idx;
                        tag_d    = core_tag;
                        state_d  = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {rd_tag, idx_q, {OFFSET_W{1'b0}}};
                if (mem_ready) state_d = REFILL;
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    wr_en         = 1'b1;
                    wr_idx        = idx_q;
                    wr_tag        = tag_q;
                    wr_data       = mem_rdata;
                    wr_be         = 4'hF;
                    wr_dirty      = 1'b0;
                    refill_pend_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            FLUSH_SCAN: begin
                if (rd_valid && rd_dirty) begin
                    state_d = FLUSH_WB;
                end else if (scan_q == LAST_IDX) begin
                    flush_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {rd_tag, scan_q, {OFFSET_W{1'b0}}};
                if (mem_ready) begin
                    clr_en = 1'b1;
                    if (scan_q == LAST_IDX) begin
                        flush_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        scan_d  = scan_q + 1'b1;
                        state_d = FLUSH_SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q       <= IDLE;
            scan_q        <= '0;
            refill_pend_q <= 1'b0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            scan_q        <= scan_d;
            refill_pend_q <= refill_pend_d;
            if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + CNT_W'(1);
            if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
        tag_q <= tag_d;
    end

endmodule

// File: doc/wb_cache.md
# wb_cache

Parametrised write-back, write-allocate, direct-mapped data cache between the MIPS core's load/store path and a multi-cycle data memory. It adds three capabilities on top of the single-cycle core's cache:
- a miss state machine that stalls the core while a dirty victim is written back and the line is refilled;
- byte-enable stores;
- a flush walk that writes back all dirty lines when the core halts.

It keeps hit/miss statistics.

## Interface
Parameters:
- LINES, 16, number of one-word lines; power of two, ≥2
- ADDR_W, 32, byte-address width
- CNT_W, 32, width of statistics counters

Ports:
- clk  in  1  sole clock, all state updates on rising edge
- rst_b  in  1  reset; synchronous, active-high (1 = reset), despite the name
- core_req  in  1  core access request; held until core_ready
- core_we  in  1  1 = store, 0 = load
- core_be  in  4  byte enables for stores (bit i = byte i, little-endian)
- core_addr  in  ADDR_W  byte address, bits [1:0] ignored
- core_wdata  in  32  store data
- core_rdata  out  32  load data, valid when core_ready & !core_we
- core_ready  out  1  access completes this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = writeback, 0 = refill
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  32  writeback data
- mem_rdata  in  32  refill data, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse
- flush  in  1  start flush (driven from halted)
- flush_done  out  1  one-cycle pulse when flush completes
- hit_cnt  out  CNT_W  saturating hit counter
- miss_cnt  out  CNT_W  saturating miss counter

## Operation
Address split:
- index = core_addr[2 +: log2(LINES)]
- tag = remaining upper bits

FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.

IDLE:
- flush=1 → FLUSH_SCAN with scan index 0. Flush has priority over core_req.
- core_req and hit (valid & tag match):
  - core_ready=1 combinationally.
  - Load: core_rdata = line data.
  - Store: bytes with core_be set are merged at the edge and dirty is set.
  - hit_cnt increments.
- core_req and miss:
  - miss_cnt increments; addr, tag and index are latched.
  - Victim valid & dirty → WRITEBACK; otherwise → REFILL.

WRITEBACK:
- mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data.
- On mem_ready → REFILL.

REFILL:
- mem_req=1, mem_we=0, mem_addr={latched tag, index, 2'b00}.
- On mem_ready: line data ← mem_rdata, tag written, valid=1, dirty=0; → IDLE.
- Back in IDLE the request hits and completes; that completion does not count as a hit.

FLUSH_SCAN:
- Line valid & dirty → FLUSH_WB.
- Otherwise advance the index; after the last line, pulse flush_done and → IDLE.

FLUSH_WB:
- Same memory handshake as WRITEBACK.
- On mem_ready: clear dirty (valid kept), advance the index, → FLUSH_SCAN; if this was the last line, pulse flush_done and → IDLE.

Rules:
- core_ready=0 in every state except an IDLE hit.
- The core holds its request stable until core_ready.
- mem_ready is ignored when mem_req=0.
- Counters saturate at all-ones.

## Timing
- Reset (rst_b=1 at an edge):
  - state=IDLE; all valid and dirty bits cleared; counters=0.
  - mem_req, mem_we, core_ready and flush_done = 0.
  - mem_addr, mem_wdata and core_rdata are don't-care.
- Reset during WRITEBACK or REFILL abandons the transfer; mem_req is low the cycle after.
- Hit: 0-cycle latency (ready in the request cycle).
- Clean miss: 1 (detect) + Lmem + 1 cycles to core_ready, where Lmem is cycles from mem_req rise to mem_ready inclusive.
- Dirty miss: 1 + 2·Lmem + 1 cycles.
- mem_req rises the cycle after the state is entered and falls the cycle after mem_ready.
- Flush of LINES lines with D dirty: LINES + D·Lmem cycles, ±1; flush_done lasts exactly one cycle.
- flush asserted while not in IDLE is sampled on the next IDLE cycle; the core holds flush high until flush_done.

## Structure
- Package cache_pkg: state enum cache_state_t; localparams OFFSET_W=2, INDEX_W=$clog2(LINES); function tag_of(addr).
- Sub-module cache_line_array: tag, data, valid and dirty storage. Provides a combinational read port, one write port with byte-enable merge, and per-line dirty clear.
- wb_cache holds the FSM, address latches, the flush scan counter and the statistics counters.

## Test plan
- Load 0x40 after reset, memory returns 0xDEADBEEF with Lmem=3 → core_ready at cycle 5, rdata=0xDEADBEEF, miss_cnt=1; repeat load → ready same cycle, hit_cnt=1.
- Store 0x11223344 be=4'b0010 to cached 0x40 (0xDEADBEEF) → later load returns 0xDEAD33EF, no memory traffic.
- LINES=16: load to 0x40+64 (same index, different tag) evicts dirty 0x40 → writeback mem_addr=0x40 with 0xDEAD33EF precedes refill of 0x80.
- Dirty lines at indices 1 and 7, flush=1 → exactly two writebacks, in index order; flush_done one cycle; both lines still valid, clean.
- rst_b=1 mid-REFILL → mem_req=0 next cycle; subsequent load of the same address misses again.
- Force hit_cnt to all-ones (CNT_W=4, 16 hits) → stays 4'hF.
